mem_responder: RTL
==================

# mem_responder

Multi-cycle memory responder that serves the CPU's instruction-fetch and data-access requests over a level-held request / single-pulse ready handshake. It replaces the zero-latency combinational memory behind the single-cycle datapath with a unified word array that inserts a programmable number of wait states. It arbitrates between the fetch and data ports and flags misaligned or out-of-range accesses.

## Interface
- DEPTH, 1024, number of 32-bit words in the array; power of two.
- WAIT, 2, wait-state cycles per access; legal range 0..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  32  fetch byte address; stable while i_req is high.
- i_ready  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched instruction word.
- i_err  out  1  fetch error; valid only with i_ready.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  32  data byte address; stable while d_req is high.
- d_wdata  in  32  store data; stable while d_req is high.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data.
- d_err  out  1  data error; valid only with d_ready.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, a request is pending:
  - grant one port;
  - latch its address, we and wdata;
  - load the wait counter with WAIT;
  - go to BUSY.
- Arbitration: one request pending, grant it. Both pending, grant the port not granted last. The last-grant flag resets to "fetch", so the data port wins the first tie.
- BUSY: if counter != 0, decrement it and stay in BUSY. If counter == 0, perform the access and go to RESP.
- Access:
  - word index = latched addr[log2(DEPTH)+1:2];
  - error if addr[1:0] != 0 or addr[31:log2(DEPTH)+2] != 0;
  - load/fetch: rdata <= array[index], or 0 on error;
  - store: array[index] <= wdata, suppressed on error.
- RESP: assert the granted port's ready (and err if flagged) for exactly one cycle, then go to IDLE.
- The fetch port is read-only; it never writes the array.
- i_rdata and d_rdata are registered and hold their last value until that port's next completion.
- A request dropped before its ready is a protocol violation. The latched access still completes and ready still pulses.
- Requester keeps req high after ready: this is treated as a new request, sampled in IDLE on the following cycle.
- Array contents are not cleared by reset.

## Timing
- Reset values:
  - i_ready, d_ready, i_err, d_err = 0;
  - i_rdata, d_rdata = 0;
  - FSM = IDLE, counter = 0, last-grant = fetch.
- Latency: a request sampled in IDLE at edge N produces ready high during cycle N+WAIT+2, i.e. WAIT+2 edges later. With WAIT=0, ready is visible 2 edges after the grant.
- Throughput per port, back-to-back with req held: one access every WAIT+3 cycles.
- Store is committed at the BUSY-exit edge. A load of the same word granted afterwards returns the new data.
- Reset asserted mid-access:
  - FSM returns to IDLE immediately; no ready pulse is produced;
  - an uncommitted store is dropped;
  - a store already committed remains.
- i_ready and d_ready are never high in the same cycle.

## Test plan
- Store then load, WAIT=2: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF. d_ready pulses 4 edges after the grant, d_err=0. Then a load from 0x10 returns d_rdata=0xDEADBEEF with d_ready.
- Fetch from 0x0 after a store of 0x20080005 to 0x0 produces i_rdata=0x20080005 with an i_ready pulse. d_ready stays 0 throughout.
- Simultaneous i_req and d_req after reset: data is served first, then fetch. Ready pulses arrive in order d_ready, then i_ready, never overlapping.
- Misaligned store to 0x13 with wdata 0x1: d_ready=1 and d_err=1, word 0x10 unchanged. Out-of-range load at byte address 4*DEPTH: d_err=1, d_rdata=0.
- WAIT=0: load completes with ready 2 edges after the grant. Held d_req gives a ready every 3 cycles.
- Reset pulse during BUSY of a store to 0x20 with 0x55: no d_ready pulse, FSM back in IDLE. A later load from 0x20 returns the prior contents.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
// Multi-cycle unified memory that serves an instruction-fetch port and a
// data port over a level-held request / one-cycle ready handshake. Each
// access waits WAIT cycles in BUSY before it touches the word array. The
// completion is then reported one cycle later through registered ready,
// err and rdata outputs.
//
// Parameters
//   DEPTH    number of 32-bit words in the array (power of two)
//   WAIT     wait-state cycles per access (0..15)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   i_req    fetch request, held until i_ready
//   i_addr   fetch byte address
//   i_ready  one-cycle fetch completion pulse
//   i_rdata  fetched word; holds until the next fetch completion
//   i_err    fetch misaligned/out-of-range flag, valid with i_ready
//   d_req    data request, held until d_ready
//   d_we     1 = store, 0 = load
//   d_addr   data byte address
//   d_wdata  store data
//   d_ready  one-cycle data completion pulse
//   d_rdata  load data; holds until the next load completion
//   d_err    data misaligned/out-of-range flag, valid with d_ready

module mem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_lastData;
    logic        r_portData;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_grant;
    logic          w_grantData;
    logic          w_commit;
    logic          w_done;
    logic          w_err;
    logic [AW-1:0] w_index;
    logic [31:0]   w_readData;

    // Address decode of the latched request. Anything with set bits above
    // the array or a non-zero byte offset is an error access.
    assign w_index    = r_addr[AW+1:2];
    assign w_err      = (r_addr[1:0] != 2'b00) || ((r_addr >> (AW + 2)) != 32'd0);
    assign w_readData = w_err ? 32'd0 : r_mem[w_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // On a tie the port that did not win last time is granted, so with
    // the flag reset to "fetch" the data port takes the first tie.
    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_grantData = 1'b0;
        w_commit    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_grantData = d_req && (!i_req || !r_lastData);
                    w_next      = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_commit = r_we && !w_err;
                    w_next   = RESP;
                end
            end
            RESP: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latched request, wait counter and registered completion outputs.
    // Reads are taken in RESP: the latched address is still stable there
    // and a store to the same word was already committed on BUSY exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_lastData <= 1'b0;
            r_portData <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            i_ready    <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= 32'd0;
            d_ready    <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'd0;
        end else begin
            i_ready <= 1'b0;
            i_err   <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            if (w_grant) begin
                r_portData <= w_grantData;
                r_lastData <= w_grantData;
                r_addr     <= w_grantData ? d_addr : i_addr;
                r_we       <= w_grantData && d_we;
                r_wdata    <= d_wdata;
                r_cnt      <= WAIT_CNT;
            end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) begin
                if (r_portData) begin
                    d_ready <= 1'b1;
                    d_err   <= w_err;
                    if (!r_we) begin
                        d_rdata <= w_readData;
                    end
                end else begin
                    i_ready <= 1'b1;
                    i_err   <= w_err;
                    i_rdata <= w_readData;
                end
            end
        end
    end

    // The array has no reset. The commit strobe depends on the FSM
    // state, which reset forces to IDLE asynchronously. That is what
    // drops an in-flight store.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_index] <= r_wdata;
        end
    end

endmodule
